// File: rtl/cpu_run_sequencer.sv
// Run/boot controller for the CPU core: holds reset, loads the boot PC, then free-runs
// or single-steps the core, counting enabled cycles until halt, self-loop, timeout or abort.
module cpu_run_sequencer #(
   parameter int unsigned PC_WIDTH       = 32,
   parameter int unsigned RESET_CYCLES   = 20,
   parameter int unsigned CNT_WIDTH      = 32,
   parameter int unsigned TIMEOUT_CYCLES = 100000,
   parameter logic [31:0] HALT_INSTR     = 32'hFFFF_FFFF,
   parameter int unsigned LOOP_LIMIT     = 4
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 start_i,
   input  logic                 step_mode_i,
   input  logic                 step_i,
   input  logic                 abort_i,
   input  logic [PC_WIDTH-1:0]  boot_pc_i,
   input  logic [PC_WIDTH-1:0]  cpu_pc_i,
   input  logic [31:0]          cpu_instr_i,
   output logic                 cpu_reset_o,
   output logic                 GOE_o,
   output logic [PC_WIDTH-1:0]  PCData_o,
   output logic                 cpu_ce_o,
   output logic [CNT_WIDTH-1:0] cycle_count_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [1:0]           status_o
);

   localparam int unsigned HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam logic [CNT_WIDTH:0] TMO_CMP = (CNT_WIDTH+1)'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {S_IDLE, S_HOLD, S_RUN, S_STEP, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [HW-1:0]        hold_q, hold_d;
   logic                 mode_q, mode_d;
   logic [PC_WIDTH-1:0]  last_pc_q, last_pc_d;
   logic [31:0]          loop_q, loop_d;
   logic                 cpu_reset_q, cpu_reset_d;
   logic                 goe_q, goe_d;
   logic [PC_WIDTH-1:0]  pcdata_q, pcdata_d;
   logic                 ce_q, ce_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic [1:0]           status_q, status_d;

   logic                 en;
   logic [CNT_WIDTH:0]   cnt_p1;
   logic [CNT_WIDTH-1:0] cnt_inc;
   logic [31:0]          loop_nx;
   logic                 hit, fin;
   logic [1:0]           hit_st, fin_st;

   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      mode_d      = mode_q;
      last_pc_d   = last_pc_q;
      loop_d      = loop_q;
      cpu_reset_d = cpu_reset_q;
      goe_d       = goe_q;
      pcdata_d    = pcdata_q;
      ce_d        = ce_q;
      cnt_d       = cnt_q;
      busy_d      = busy_q;
      done_d      = done_q;
      status_d    = status_q;
      fin         = 1'b0;
      fin_st      = 2'b00;

      // A core cycle only counts when the core was clocked and out of reset.
      en      = ce_q && !cpu_reset_q;
      cnt_p1  = {1'b0, cnt_q} + (CNT_WIDTH+1)'(1);
      cnt_inc = cnt_p1[CNT_WIDTH] ? cnt_q : cnt_p1[CNT_WIDTH-1:0];
      loop_nx = (loop_q != 32'd0 && cpu_pc_i == last_pc_q) ? loop_q + 32'd1 : 32'd1;

      hit    = 1'b0;
      hit_st = 2'b00;
      if (cpu_instr_i == HALT_INSTR) begin
         hit    = 1'b1;
         hit_st = 2'b01;
      end else if (LOOP_LIMIT != 0 && loop_nx >= LOOP_LIMIT) begin
         hit    = 1'b1;
         hit_st = 2'b10;
      end else if (TIMEOUT_CYCLES != 0 && cnt_p1 == TMO_CMP) begin
         hit    = 1'b1;
         hit_st = 2'b11;
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               state_d     = S_HOLD;
               pcdata_d    = boot_pc_i;
               mode_d      = step_mode_i;
               cnt_d       = '0;
               status_d    = 2'b00;
               loop_d      = 32'd0;
               hold_d      = HW'(RESET_CYCLES - 1);
               cpu_reset_d = 1'b1;
               goe_d       = 1'b1;
               ce_d        = 1'b1;
               busy_d      = 1'b1;
               done_d      = 1'b0;
            end
         end
         S_HOLD: begin
            if (abort_i) begin
               fin    = 1'b1;
               fin_st = 2'b11;
            end else if (hold_q == '0) begin
               state_d     = mode_q ? S_STEP : S_RUN;
               cpu_reset_d = 1'b0;
               ce_d        = !mode_q;
            end else begin
               hold_d = hold_q - HW'(1);
            end
         end
         S_RUN, S_STEP: begin
            if (abort_i) begin
               fin    = 1'b1;
               fin_st = 2'b11;
            end else begin
               if (en) begin
                  cnt_d     = cnt_inc;
                  loop_d    = loop_nx;
                  last_pc_d = cpu_pc_i;
                  fin       = hit;
                  fin_st    = hit_st;
               end
               ce_d = (state_q == S_RUN) || step_i;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Completion overrides any pending step; the core stays out of reset for inspection.
      if (fin) begin
         state_d     = S_DONE;
         status_d    = fin_st;
         ce_d        = 1'b0;
         cpu_reset_d = 1'b0;
         goe_d       = 1'b1;
         busy_d      = 1'b0;
         done_d      = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= S_IDLE;
         hold_q      <= '0;
         mode_q      <= 1'b0;
         last_pc_q   <= '0;
         loop_q      <= 32'd0;
         cpu_reset_q <= 1'b1;
         goe_q       <= 1'b0;
         pcdata_q    <= '0;
         ce_q        <= 1'b0;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         status_q    <= 2'b00;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         mode_q      <= mode_d;
         last_pc_q   <= last_pc_d;
         loop_q      <= loop_d;
         cpu_reset_q <= cpu_reset_d;
         goe_q       <= goe_d;
         pcdata_q    <= pcdata_d;
         ce_q        <= ce_d;
         cnt_q       <= cnt_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         status_q    <= status_d;
      end
   end

   assign cpu_reset_o   = cpu_reset_q;
   assign GOE_o         = goe_q;
   assign PCData_o      = pcdata_q;
   assign cpu_ce_o      = ce_q;
   assign cycle_count_o = cnt_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign status_o      = status_q;

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// Randomized bench for cpu_run_sequencer: per-enabled-cycle PC/instruction scripts are
// scored against a run-length/priority model of the completion rules.
module tb_cpu_run_sequencer;

   localparam int unsigned RC   = 20;
   localparam int unsigned TMO  = 50;
   localparam int unsigned LL   = 4;
   localparam logic [31:0] HALT = 32'hFFFF_FFFF;

   logic        clk_i = 1'b0;
   logic        reset_i, start_i, step_mode_i, step_i, abort_i;
   logic [31:0] boot_pc_i, cpu_pc_i, cpu_instr_i;
   logic        cpu_reset_o, GOE_o, cpu_ce_o, busy_o, done_o;
   logic [31:0] PCData_o, cycle_count_o;
   logic [1:0]  status_o;

   int checks = 0;
   int errors = 0;

   logic [31:0] pc_seq [0:127];
   logic [31:0] in_seq [0:127];

   cpu_run_sequencer #(
      .PC_WIDTH(32), .RESET_CYCLES(RC), .CNT_WIDTH(32),
      .TIMEOUT_CYCLES(TMO), .HALT_INSTR(HALT), .LOOP_LIMIT(LL)
   ) dut (
      .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .step_mode_i(step_mode_i),
      .step_i(step_i), .abort_i(abort_i), .boot_pc_i(boot_pc_i), .cpu_pc_i(cpu_pc_i),
      .cpu_instr_i(cpu_instr_i), .cpu_reset_o(cpu_reset_o), .GOE_o(GOE_o),
      .PCData_o(PCData_o), .cpu_ce_o(cpu_ce_o), .cycle_count_o(cycle_count_o),
      .busy_o(busy_o), .done_o(done_o), .status_o(status_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic cyc();
      @(posedge clk_i);
      #1;
      cpu_pc_i = cpu_pc_i + 32'd4;
   endtask

   // Expected stop point from the rules: halt > self-loop run length > timeout.
   function automatic void predict(output int stop, output logic [1:0] st);
      int run;
      stop = -1; st = 2'b00; run = 0;
      for (int e = 1; e < 128; e++) begin
         if (e > 1 && pc_seq[e] == pc_seq[e-1]) run++;
         else run = 1;
         if (in_seq[e] == HALT) begin stop = e; st = 2'b01; return; end
         if (run >= int'(LL)) begin stop = e; st = 2'b10; return; end
         if (e == int'(TMO)) begin stop = e; st = 2'b11; return; end
      end
   endfunction

   task automatic fill_unique();
      logic [31:0] base;
      base = $urandom & 32'hFFF0_0000;
      for (int i = 0; i < 128; i++) begin
         pc_seq[i] = base + 32'(i) * 32'd4;
         in_seq[i] = $urandom & 32'h7FFF_FFFF;
      end
   endtask

   task automatic boot(input logic [31:0] pc, input logic mode, output int hold_n);
      start_i = 1'b1; boot_pc_i = pc; step_mode_i = mode;
      cyc();
      start_i = 1'b0; boot_pc_i = $urandom; step_mode_i = 1'($urandom_range(0, 1));
      hold_n = 0;
      while (cpu_reset_o === 1'b1 && hold_n < 100) begin
         hold_n++;
         cyc();
      end
   endtask

   // Acts as the core: presents the scripted PC/instr on each enabled cycle.
   task automatic drive_run(input logic mode, input int pct, output int e_obs, output int ce_bad);
      int n;
      logic s, prev;
      e_obs = 0; ce_bad = 0; n = 0; prev = 1'b0;
      while (done_o !== 1'b1 && n < 400) begin
         if (cpu_ce_o !== (mode ? prev : 1'b1)) ce_bad++;
         if (cpu_ce_o === 1'b1 && cpu_reset_o === 1'b0 && e_obs < 127) begin
            e_obs++;
            cpu_pc_i = pc_seq[e_obs]; cpu_instr_i = in_seq[e_obs];
         end else begin
            cpu_instr_i = 32'd0;
         end
         s = mode && ($urandom_range(0, 99) < pct);
         step_i = s; prev = s;
         cyc();
         n++;
      end
      step_i = 1'b0; cpu_instr_i = 32'd0;
      if (done_o !== 1'b1) e_obs = -1;
   endtask

   task automatic test_reset();
      reset_i = 1'b1; start_i = 0; step_mode_i = 0; step_i = 0; abort_i = 0;
      boot_pc_i = 32'h1234_5678; cpu_pc_i = 0; cpu_instr_i = 0;
      cyc(); cyc();
      checks++;
      if ({cpu_reset_o, GOE_o, cpu_ce_o, busy_o, done_o, status_o} !== 7'b1000000 ||
          PCData_o !== 32'd0 || cycle_count_o !== 32'd0) begin
         errors++;
         $display("FAIL reset_values: rst=%b goe=%b ce=%b busy=%b done=%b st=%b pc=%h cnt=%0d",
                  cpu_reset_o, GOE_o, cpu_ce_o, busy_o, done_o, status_o, PCData_o, cycle_count_o);
      end
      reset_i = 1'b0;
      abort_i = 1'b1; cyc(); abort_i = 1'b0; cyc();
      checks++;
      if ({cpu_reset_o, GOE_o, busy_o, done_o} !== 4'b1000) begin
         errors++;
         $display("FAIL idle_abort_ignored: rst=%b goe=%b busy=%b done=%b want 1000",
                  cpu_reset_o, GOE_o, busy_o, done_o);
      end
   endtask

   task automatic test_boot();
      int n, ce_n;
      start_i = 1'b1; boot_pc_i = 32'h0; step_mode_i = 1'b0;
      cyc();
      start_i = 1'b0; boot_pc_i = 32'hFFFF_0000;
      checks++;
      if ({cpu_reset_o, GOE_o, cpu_ce_o, busy_o, done_o} !== 5'b11110 || PCData_o !== 32'd0) begin
         errors++;
         $display("FAIL boot_hold: rst=%b goe=%b ce=%b busy=%b done=%b pc=%h want 11110 pc=0",
                  cpu_reset_o, GOE_o, cpu_ce_o, busy_o, done_o, PCData_o);
      end
      n = 0;
      while (cpu_reset_o === 1'b1 && n < 100) begin n++; cyc(); end
      checks++;
      if (n != int'(RC)) begin
         errors++; $display("FAIL boot_reset_len: got %0d want %0d", n, RC);
      end
      ce_n = 0;
      for (int i = 0; i < 10; i++) begin
         if (cpu_ce_o === 1'b1 && busy_o === 1'b1 && GOE_o === 1'b1) ce_n++;
         cyc();
      end
      checks++;
      if (ce_n != 10 || cycle_count_o !== 32'd10) begin
         errors++;
         $display("FAIL boot_run: ce_cycles=%0d cnt=%0d want 10/10", ce_n, cycle_count_o);
      end
      abort_i = 1'b1; cyc(); abort_i = 1'b0;
   endtask

   task automatic test_halt();
      int n, e, bad, k, stop;
      logic [1:0] st;
      for (int rep = 0; rep < 3; rep++) begin
         fill_unique();
         k = (rep == 0) ? 37 : $urandom_range(1, 45);
         in_seq[k] = HALT;
         predict(stop, st);
         boot($urandom, 1'b0, n);
         drive_run(1'b0, 0, e, bad);
         checks++;
         if (e != stop || bad != 0) begin
            errors++; $display("FAIL halt_enables: got %0d bad=%0d want %0d", e, bad, stop);
         end
         checks++;
         if (status_o !== st || cycle_count_o !== 32'(stop)) begin
            errors++;
            $display("FAIL halt_result: st=%b cnt=%0d want %b/%0d", status_o, cycle_count_o, st, stop);
         end
         cyc(); cyc(); cyc();
         checks++;
         if ({cpu_ce_o, done_o, busy_o, cpu_reset_o, GOE_o} !== 5'b01001 ||
             cycle_count_o !== 32'(stop)) begin
            errors++;
            $display("FAIL halt_frozen: ce=%b done=%b busy=%b rst=%b goe=%b cnt=%0d",
                     cpu_ce_o, done_o, busy_o, cpu_reset_o, GOE_o, cycle_count_o);
         end
      end
   endtask

   task automatic test_loop();
      int n, e, bad, stop;
      logic [1:0] st;
      for (int rep = 0; rep < 4; rep++) begin
         fill_unique();
         for (int i = 1; i < 128; i++)
            if (rep == 0) pc_seq[i] = 32'h40;
            else if (rep == 1 && i > 7) pc_seq[i] = 32'h40;
            else if (rep > 1) pc_seq[i] = 32'h40 + 32'd4 * 32'($urandom_range(0, 1));
         predict(stop, st);
         boot($urandom, 1'b0, n);
         drive_run(1'b0, 0, e, bad);
         checks++;
         if (e != stop || status_o !== st || cycle_count_o !== 32'(stop)) begin
            errors++;
            $display("FAIL loop_result rep%0d: enables=%0d st=%b cnt=%0d want %0d/%b",
                     rep, e, status_o, cycle_count_o, stop, st);
         end
      end
   endtask

   task automatic test_timeout();
      int n, e, bad, stop;
      logic [1:0] st;
      for (int m = 0; m < 2; m++) begin
         fill_unique();
         predict(stop, st);
         boot($urandom, 1'(m), n);
         drive_run(1'(m), 60, e, bad);
         checks++;
         if (e != stop || bad != 0 || status_o !== 2'b11 || cycle_count_o !== 32'(TMO)) begin
            errors++;
            $display("FAIL timeout mode%0d: enables=%0d bad=%0d st=%b cnt=%0d want %0d/11",
                     m, e, bad, status_o, cycle_count_o, TMO);
         end
      end
   endtask

   task automatic test_step();
      logic sseq [18] = '{1,0,0,1,0,0,0,1,0,0,1,1,1,1,1,0,0,0};
      int n, bad, pulses, e, stop;
      logic [1:0] st;
      logic exp;
      boot($urandom, 1'b1, n);
      bad = 0; pulses = 0;
      for (int t = 0; t < 18; t++) begin
         exp = (t == 0) ? 1'b0 : sseq[t-1];
         if (cpu_ce_o !== exp) bad++;
         if (cpu_ce_o === 1'b1) pulses++;
         step_i = sseq[t];
         cyc();
      end
      step_i = 1'b0;
      checks++;
      if (pulses != 8 || bad != 0 || cycle_count_o !== 32'd8 || busy_o !== 1'b1) begin
         errors++;
         $display("FAIL step_pulses: pulses=%0d bad=%0d cnt=%0d busy=%b want 8/0/8/1",
                  pulses, bad, cycle_count_o, busy_o);
      end
      abort_i = 1'b1; cyc(); abort_i = 1'b0;
      // random steps, and steps held solid while a halt arrives
      for (int rep = 0; rep < 2; rep++) begin
         fill_unique();
         in_seq[(rep == 0) ? $urandom_range(5, 30) : $urandom_range(1, 10)] = HALT;
         predict(stop, st);
         boot($urandom, 1'b1, n);
         drive_run(1'b1, (rep == 0) ? 40 : 100, e, bad);
         checks++;
         if (e != stop || bad != 0 || status_o !== st || cycle_count_o !== 32'(stop)) begin
            errors++;
            $display("FAIL step_halt rep%0d: enables=%0d bad=%0d st=%b cnt=%0d want %0d/%b",
                     rep, e, bad, status_o, cycle_count_o, stop, st);
         end
         checks++;
         if (cpu_ce_o !== 1'b0 || done_o !== 1'b1) begin
            errors++; $display("FAIL step_dropped: ce=%b done=%b want 0/1", cpu_ce_o, done_o);
         end
      end
   endtask

   task automatic test_abort();
      int n;
      boot(32'h0000_1000, 1'b0, n);
      repeat (5) cyc();
      abort_i = 1'b1; start_i = 1'b1; boot_pc_i = 32'h0000_2000;
      cyc();
      abort_i = 1'b0; start_i = 1'b0;
      checks++;
      if ({cpu_reset_o, GOE_o, cpu_ce_o, busy_o, done_o, status_o} !== 7'b0100111) begin
         errors++;
         $display("FAIL abort_run: rst=%b goe=%b ce=%b busy=%b done=%b st=%b want 0100111",
                  cpu_reset_o, GOE_o, cpu_ce_o, busy_o, done_o, status_o);
      end
      repeat (3) cyc();
      checks++;
      if ({cpu_reset_o, busy_o, done_o} !== 3'b001 || PCData_o !== 32'h0000_1000) begin
         errors++;
         $display("FAIL abort_no_restart: rst=%b busy=%b done=%b pc=%h",
                  cpu_reset_o, busy_o, done_o, PCData_o);
      end
      start_i = 1'b1; boot_pc_i = 32'h0000_3000; cyc(); start_i = 1'b0;
      checks++;
      if ({cpu_reset_o, busy_o, done_o, status_o} !== 5'b11000 || cycle_count_o !== 32'd0 ||
          PCData_o !== 32'h0000_3000) begin
         errors++;
         $display("FAIL restart_from_done: rst=%b busy=%b done=%b st=%b cnt=%0d pc=%h",
                  cpu_reset_o, busy_o, done_o, status_o, cycle_count_o, PCData_o);
      end
      repeat (5) cyc();
      abort_i = 1'b1; cyc(); abort_i = 1'b0;
      checks++;
      if ({cpu_reset_o, done_o, busy_o, status_o} !== 5'b01011) begin
         errors++;
         $display("FAIL abort_hold: rst=%b done=%b busy=%b st=%b want 01011",
                  cpu_reset_o, done_o, busy_o, status_o);
      end
   endtask

   task automatic test_midrun_reset();
      int n;
      boot($urandom, 1'b0, n);
      repeat (7) cyc();
      reset_i = 1'b1; cyc(); reset_i = 1'b0;
      checks++;
      if ({cpu_reset_o, GOE_o, cpu_ce_o, busy_o, done_o, status_o} !== 7'b1000000 ||
          PCData_o !== 32'd0 || cycle_count_o !== 32'd0) begin
         errors++;
         $display("FAIL midrun_reset: rst=%b goe=%b ce=%b busy=%b done=%b st=%b pc=%h cnt=%0d",
                  cpu_reset_o, GOE_o, cpu_ce_o, busy_o, done_o, status_o, PCData_o, cycle_count_o);
      end
      cyc();
      boot(32'h0040_0000, 1'b0, n);
      checks++;
      if (n != int'(RC) || PCData_o !== 32'h0040_0000 || busy_o !== 1'b1 || cpu_ce_o !== 1'b1) begin
         errors++;
         $display("FAIL reboot: hold=%0d pc=%h busy=%b ce=%b want %0d/00400000/1/1",
                  n, PCData_o, busy_o, cpu_ce_o, RC);
      end
      abort_i = 1'b1; cyc(); abort_i = 1'b0;
   endtask

   initial begin
      test_reset();
      test_boot();
      test_halt();
      test_loop();
      test_timeout();
      test_step();
      test_abort();
      test_midrun_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
